// File: rtl/cordic_stream.sv
// Pipelined CORDIC with valid/ready streaming and per-sample mode (rotate/vector).
// Define CORDIC_GAIN_COMP_EN to add an output stage that removes the CORDIC gain K.
module cordic_stream #(
  parameter int XY_BITS    = 16,
  parameter int PH_BITS    = 32,
  parameter int ITERATIONS = 16,
  parameter int TAG_BITS   = 4,
  localparam int W         = XY_BITS + 2,
  localparam int OCC_W     = $clog2(ITERATIONS + 3)
) (
  input  logic                       clk,
  input  logic                       RST_N,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_mode,
  input  logic signed [XY_BITS-1:0]  in_x,
  input  logic signed [XY_BITS-1:0]  in_y,
  input  logic        [PH_BITS-1:0]  in_phase,
  input  logic        [TAG_BITS-1:0] in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_mode,
  output logic signed [W-1:0]        out_x,
  output logic signed [W-1:0]        out_y,
  output logic        [PH_BITS-1:0]  out_phase,
  output logic        [TAG_BITS-1:0] out_tag,
  output logic        [OCC_W-1:0]    occupancy
);
  localparam int LAST = ITERATIONS;

  // Handshake: a transfer happens on a rising edge where valid && ready are both high;
  // the whole pipeline shifts together only when the output register is empty or drained.
  function automatic logic [PH_BITS-1:0] atan_lut(input int i);
    logic [31:0] t;
    case (i)
      0: t = 32'h20000000;  1: t = 32'h12E4051E;  2: t = 32'h09FB385B;  3: t = 32'h051111D4;
      4: t = 32'h028B0D43;  5: t = 32'h0145D7E1;  6: t = 32'h00A2F61E;  7: t = 32'h00517C55;
      8: t = 32'h0028BE53;  9: t = 32'h00145F2F; 10: t = 32'h000A2F98; 11: t = 32'h000517CC;
     12: t = 32'h00028BE6; 13: t = 32'h000145F3; 14: t = 32'h0000A2FA; 15: t = 32'h0000517D;
     16: t = 32'h000028BE; 17: t = 32'h0000145F; 18: t = 32'h00000A30; 19: t = 32'h00000518;
     20: t = 32'h0000028C; 21: t = 32'h00000146; 22: t = 32'h000000A3; 23: t = 32'h00000051;
     24: t = 32'h00000029; 25: t = 32'h00000014; 26: t = 32'h0000000A; 27: t = 32'h00000005;
     28: t = 32'h00000003; 29: t = 32'h00000001; 30: t = 32'h00000001;
     default: t = 32'h00000000;
    endcase
    return PH_BITS'(t >> (32 - PH_BITS));
  endfunction

  logic [LAST:0]              r_v;
  logic [LAST:0]              r_m;
  logic signed [W-1:0]        r_x [0:LAST];
  logic signed [W-1:0]        r_y [0:LAST];
  logic [PH_BITS-1:0]         r_z [0:LAST];
  logic [TAG_BITS-1:0]        r_t [0:LAST];
  logic [OCC_W-1:0]           r_occ;
  logic signed [W-1:0]        w_nx [1:LAST];
  logic signed [W-1:0]        w_ny [1:LAST];
  logic [PH_BITS-1:0]         w_nz [1:LAST];
  logic signed [W-1:0]        w_xe, w_ye, w_x0, w_y0;
  logic [PH_BITS-1:0]         w_z0;
  logic                       w_adv, w_acc, w_done;

  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv && !flush;
  assign w_acc    = in_valid && in_ready;
  assign w_done   = out_valid && out_ready;
  assign w_xe     = W'(in_x);
  assign w_ye     = W'(in_y);

  // Quadrant pre-step: brings the angle into the range the micro-rotations can reach.
  always_comb begin
    w_x0 = w_xe;
    w_y0 = w_ye;
    w_z0 = in_phase;
    if (in_mode) begin
      if (w_xe[W-1]) begin
        w_x0 = -w_xe;
        w_y0 = -w_ye;
        w_z0 = in_phase + {1'b1, {(PH_BITS-1){1'b0}}};
      end
    end else begin
      w_z0 = {2'b00, in_phase[PH_BITS-3:0]};
      case (in_phase[PH_BITS-1:PH_BITS-2])
        2'b01:   begin w_x0 = -w_ye; w_y0 = w_xe;  end
        2'b10:   begin w_x0 = -w_xe; w_y0 = -w_ye; end
        2'b11:   begin w_x0 = w_ye;  w_y0 = -w_xe; end
        default: ;
      endcase
    end
  end

  for (genvar k = 1; k <= LAST; k++) begin : g_rot
    localparam logic [PH_BITS-1:0] ATAN = atan_lut(k - 1);
    logic signed [W-1:0] w_xs, w_ys;
    logic                w_pos;
    assign w_xs  = r_x[k-1] >>> (k - 1);
    assign w_ys  = r_y[k-1] >>> (k - 1);
    // w_pos selects x+=y, y-=x, z+=atan: y>0 when vectoring, z<0 when rotating.
    assign w_pos = r_m[k-1] ? (!r_y[k-1][W-1] && (r_y[k-1] != '0)) : r_z[k-1][PH_BITS-1];
    assign w_nx[k] = w_pos ? r_x[k-1] + w_ys : r_x[k-1] - w_ys;
    assign w_ny[k] = w_pos ? r_y[k-1] - w_xs : r_y[k-1] + w_xs;
    assign w_nz[k] = w_pos ? r_z[k-1] + ATAN : r_z[k-1] - ATAN;
  end

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      r_v   <= '0;
      r_m   <= '0;
      r_occ <= '0;
      for (int k = 0; k <= LAST; k++) begin
        r_x[k] <= '0;
        r_y[k] <= '0;
        r_z[k] <= '0;
        r_t[k] <= '0;
      end
    end else begin
      if (flush)      r_v <= '0;
      else if (w_adv) r_v <= {r_v[LAST-1:0], w_acc};
      if (w_adv && !flush) begin
        r_x[0] <= w_x0;
        r_y[0] <= w_y0;
        r_z[0] <= w_z0;
        r_t[0] <= in_tag;
        r_m    <= {r_m[LAST-1:0], in_mode};
        for (int k = 1; k <= LAST; k++) begin
          r_x[k] <= w_nx[k];
          r_y[k] <= w_ny[k];
          r_z[k] <= w_nz[k];
          r_t[k] <= r_t[k-1];
        end
      end
      if (flush)                r_occ <= '0;
      else if (w_acc && !w_done) r_occ <= r_occ + 1'b1;
      else if (!w_acc && w_done) r_occ <= r_occ - 1'b1;
    end
  end

  assign occupancy = r_occ;

`ifdef CORDIC_GAIN_COMP_EN
  localparam int PW = W + XY_BITS + 1;
  localparam int GAIN = int'(0.6072529350088813 * (2.0 ** XY_BITS));
  localparam logic signed [PW-1:0] GAIN_S = PW'(GAIN);
  localparam logic signed [PW-1:0] RND    = PW'(1) << (XY_BITS - 1);
  logic signed [PW-1:0]  w_px, w_py;
  logic                  r_gv, r_gm;
  logic signed [W-1:0]   r_gx, r_gy;
  logic [PH_BITS-1:0]    r_gz;
  logic [TAG_BITS-1:0]   r_gt;

  assign w_px = (PW'(r_x[LAST]) * GAIN_S + RND) >>> XY_BITS;
  assign w_py = (PW'(r_y[LAST]) * GAIN_S + RND) >>> XY_BITS;

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      r_gv <= 1'b0;
      r_gm <= 1'b0;
      r_gx <= '0;
      r_gy <= '0;
      r_gz <= '0;
      r_gt <= '0;
    end else begin
      if (flush)      r_gv <= 1'b0;
      else if (w_adv) r_gv <= r_v[LAST];
      if (w_adv && !flush) begin
        r_gm <= r_m[LAST];
        r_gx <= W'(w_px);
        r_gy <= W'(w_py);
        r_gz <= r_z[LAST];
        r_gt <= r_t[LAST];
      end
    end
  end

  assign out_valid = r_gv;
  assign out_mode  = r_gm;
  assign out_x     = r_gx;
  assign out_y     = r_gy;
  assign out_phase = r_gz;
  assign out_tag   = r_gt;
`else
  assign out_valid = r_v[LAST];
  assign out_mode  = r_m[LAST];
  assign out_x     = r_x[LAST];
  assign out_y     = r_y[LAST];
  assign out_phase = r_z[LAST];
  assign out_tag   = r_t[LAST];
`endif
endmodule

// File: doc/cordic_stream.md
Name: cordic_stream

Overview:
Pipelined, parametrised CORDIC engine with a valid/ready stream interface. Each sample selects its own mode: rotation (rotate vector by phase) or vectoring (magnitude and atan2). Full four-quadrant range in both modes, stall-capable pipeline, tag passthrough and an occupancy counter. It sits between the NCO/phase accumulator and the modulator/demodulator datapaths, which currently need fixed-mode, non-stallable CORDIC instances.

Parameters:
XY_BITS, 16, signed width of in_x/in_y; internal and output width W = XY_BITS+2 (guard for gain 1.647 and the quadrant step)
PH_BITS, 32, unsigned phase width; 2^PH_BITS = 2π; legal 8..32
ITERATIONS, 16, number of micro-rotation stages; legal 4..32
TAG_BITS, 4, width of the sideband tag carried alongside each sample; legal ≥1

Ports:
clk  in  1  clock, all logic on rising edge
RST_N  in  1  asynchronous active-low reset
flush  in  1  synchronous drop of all in-flight samples
in_valid  in  1  input sample valid
in_ready  out  1  engine accepts a sample this cycle
in_mode  in  1  0 = rotate, 1 = vector
in_x  in  XY_BITS  signed x
in_y  in  XY_BITS  signed y
in_phase  in  PH_BITS  rotate: angle; vector: initial phase offset (normally 0)
in_tag  in  TAG_BITS  opaque sideband
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_mode  out  1  mode of the presented result
out_x  out  W  signed x result
out_y  out  W  signed y result
out_phase  out  PH_BITS  phase result, modulo 2^PH_BITS
out_tag  out  TAG_BITS  tag of the presented result
occupancy  out  $clog2(ITERATIONS+3)  number of valid samples in flight

Behaviour:
- Reset (RST_N low, async): all stage valid bits, out_* registers and occupancy cleared to 0; in_ready = 1 once reset is released.
- Pipeline: stage 0 (quadrant pre-step), stages 1..ITERATIONS (micro-rotations); the last stage drives out_*. Latency L = ITERATIONS+1 cycles from accept edge to out_valid without stall.
- Advance: adv = !out_valid || out_ready; every stage shifts only when adv. in_ready = adv && !flush (combinational). Bubbles are not compressed.
- Accept = in_valid && in_ready. Holding in_valid without in_ready changes nothing.
- Rotate pre-step on phase[PH_BITS-1:PH_BITS-2]: 00 → (x,y); 01 → (-y,x); 10 → (-x,-y); 11 → (y,-x). z0 = phase with top 2 bits cleared.
- Rotate stage i: d = sign(z). z<0 → x+=y>>>i, y-=x>>>i, z+=atan(i); else the opposite. The final z (residual) is output as out_phase.
- Vector pre-step: x<0 → (-x,-y), z0 = in_phase + 2^(PH_BITS-1); else z0 = in_phase. Stage i: y>0 → x+=y>>>i, y-=x>>>i, z+=atan(i); else the opposite. out_x = |v|·K, out_y ≈ 0, out_phase = atan2 in [0, 2π).
- atan(i) = round(2^PH_BITS·atan(2^-i)/2π). Generated as the 32-bit table (0x20000000, 0x12E4051E, …) right-shifted by 32-PH_BITS.
- Arithmetic: inputs sign-extended to W. Shifts are arithmetic. No saturation inside W. Phase adds wrap modulo 2^PH_BITS. Negating -2^(XY_BITS-1) is exact thanks to the guard bits.
- Gain K ≈ 1.64676 is uncompensated unless the option below is built in.
- Occupancy: +1 on accept, -1 on output handshake, unchanged when both occur; 0 after flush.
- Flush: on the next edge all valid bits clear and occupancy becomes 0. An accept in the same cycle is blocked. Data registers keep their values.
- Reset mid-stream discards everything; no partial output is produced.

Optional Feature:
CORDIC_GAIN_COMP_EN.
- Defined: one extra output stage multiplies x and y by round(2^XY_BITS/K), then shifts arithmetic right by XY_BITS, rounding half-up. L = ITERATIONS+2. The stall rule and occupancy range are extended to cover this stage.
- Undefined: no multiplier; outputs carry gain K; L = ITERATIONS+1.

Test Plan (XY_BITS=16, PH_BITS=32, ITERATIONS=16, option off unless stated):
- Rotate: x=10000, y=0, phase=0x40000000 → out_x = 0±4, out_y = 16468±4, out_valid exactly 17 cycles after accept.
- Vector: x=-10000, y=0, phase=0 → out_x = 16468±4, out_phase = 0x80000000±2^17. Then x=0, y=-5000 → out_phase = 0xC0000000±2^17.
- Backpressure: 20 back-to-back samples with tags 0..19; out_ready low for cycles 20-24 → in_ready low exactly while out_valid && !out_ready; all 20 results emerge in order, none lost or duplicated; occupancy peaks at 17.
- Flush: 5 samples in flight, pulse flush → next cycle occupancy = 0, out_valid = 0; a sample accepted afterwards is the only output, after 17 cycles.
- Async reset: assert RST_N low mid-stream between clock edges → out_valid and occupancy go to 0 immediately; after release, in_ready = 1.
- CORDIC_GAIN_COMP_EN defined: rotate x=10000, y=0, phase=0x20000000 → out_x = out_y = 7071±3, latency 18.
